// File: rtl/addr_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : addr_mode_sequencer
// Function : Sequences the operand-address bus steps of one addressing mode
//            per start pulse, driving the address-mux select and pointer
//            register latch strobes. Stalls on memory wait.
// Revision : 1.0
// ============================================================================
module addr_mode_sequencer #(
    parameter int WAIT_ENABLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] mode,
    input  logic       mem_ready,
    output logic [3:0] address_select,
    output logic       mem_req,
    output logic       pc_inc,
    output logic       dirl_load,
    output logic       dirh_load,
    output logic       indirl_load,
    output logic       indirh_load,
    output logic       operand_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] M_IMP = 3'd0;
    localparam logic [2:0] M_IMM = 3'd1;
    localparam logic [2:0] M_ZP  = 3'd2;
    localparam logic [2:0] M_ABS = 3'd3;
    localparam logic [2:0] M_IZP = 3'd4;
    localparam logic [2:0] M_IAB = 3'd5;
    localparam logic [2:0] M_STK = 3'd6;
    localparam logic [2:0] M_NMI = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP1 = 3'd1,
        S_STEP2 = 3'd2,
        S_STEP3 = 3'd3,
        S_STEP4 = 3'd4
    } state_t;

    typedef struct packed {
        logic pc_inc;
        logic dirl;
        logic dirh;
        logic indirl;
        logic indirh;
        logic opv;
        logic last;
    } step_t;

    // Address-mux source used by step idx (0-based) of mode m.
    function automatic logic [3:0] sel_of(input logic [2:0] m, input logic [1:0] idx);
        logic [3:0] s;
        s = 4'h0;
        case ({m, idx})
            {M_ZP,  2'd1}: s = 4'h1;
            {M_ABS, 2'd2}: s = 4'h2;
            {M_IZP, 2'd1}: s = 4'h3;
            {M_IZP, 2'd2}: s = 4'h4;
            {M_IZP, 2'd3}: s = 4'h2;
            {M_IAB, 2'd2}: s = 4'h5;
            {M_IAB, 2'd3}: s = 4'h6;
            {M_STK, 2'd0}: s = 4'h7;
            {M_NMI, 2'd0}: s = 4'h8;
            {M_NMI, 2'd1}: s = 4'h9;
            default:       s = 4'h0;
        endcase
        return s;
    endfunction

    // Strobes raised when step idx of mode m is accepted, plus end-of-sequence flag.
    function automatic step_t step_of(input logic [2:0] m, input logic [1:0] idx);
        step_t s;
        s = '0;
        case ({m, idx})
            {M_IMM, 2'd0}: begin s.pc_inc = 1'b1; s.opv = 1'b1; s.last = 1'b1; end
            {M_ZP,  2'd0}: begin s.dirl = 1'b1; s.pc_inc = 1'b1; end
            {M_ZP,  2'd1}: begin s.opv = 1'b1; s.last = 1'b1; end
            {M_ABS, 2'd0}: begin s.dirl = 1'b1; s.pc_inc = 1'b1; end
            {M_ABS, 2'd1}: begin s.dirh = 1'b1; s.pc_inc = 1'b1; end
            {M_ABS, 2'd2}: begin s.opv = 1'b1; s.last = 1'b1; end
            {M_IZP, 2'd0}: begin s.indirl = 1'b1; s.pc_inc = 1'b1; end
            {M_IZP, 2'd1}: s.dirl = 1'b1;
            {M_IZP, 2'd2}: s.dirh = 1'b1;
            {M_IZP, 2'd3}: begin s.opv = 1'b1; s.last = 1'b1; end
            {M_IAB, 2'd0}: begin s.indirl = 1'b1; s.pc_inc = 1'b1; end
            {M_IAB, 2'd1}: begin s.indirh = 1'b1; s.pc_inc = 1'b1; end
            {M_IAB, 2'd2}: s.dirl = 1'b1;
            {M_IAB, 2'd3}: begin s.dirh = 1'b1; s.last = 1'b1; end
            {M_STK, 2'd0}: begin s.opv = 1'b1; s.last = 1'b1; end
            {M_NMI, 2'd0}: s.dirl = 1'b1;
            {M_NMI, 2'd1}: begin s.dirh = 1'b1; s.last = 1'b1; end
            default:       s = '0;
        endcase
        return s;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [3:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0] step_idx;
    logic       step_ready;
    logic       accept;
    step_t      cur;

    always_comb begin
        step_idx = 2'd0;
        case (state_q)
            S_STEP2: step_idx = 2'd1;
            S_STEP3: step_idx = 2'd2;
            S_STEP4: step_idx = 2'd3;
            default: step_idx = 2'd0;
        endcase
    end

    assign step_ready = (WAIT_ENABLE == 0) ? 1'b1 : mem_ready;
    assign mem_req    = (state_q != S_IDLE);
    assign accept     = mem_req && step_ready;
    assign cur        = step_of(mode_q, step_idx);

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        sel_d         = sel_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        pc_inc        = 1'b0;
        dirl_load     = 1'b0;
        dirh_load     = 1'b0;
        indirl_load   = 1'b0;
        indirh_load   = 1'b0;
        operand_valid = 1'b0;

        if (state_q == S_IDLE) begin
            sel_d  = 4'h0;
            busy_d = 1'b0;
            if (start) begin
                mode_d = mode;
                if (mode == M_IMP) begin
                    // No bus steps: finish straight from IDLE.
                    done_d = 1'b1;
                end else begin
                    state_d = S_STEP1;
                    busy_d  = 1'b1;
                    sel_d   = sel_of(mode, 2'd0);
                end
            end
        end else if (accept) begin
            pc_inc        = cur.pc_inc;
            dirl_load     = cur.dirl;
            dirh_load     = cur.dirh;
            indirl_load   = cur.indirl;
            indirh_load   = cur.indirh;
            operand_valid = cur.opv;
            if (cur.last) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                sel_d   = 4'h0;
            end else begin
                sel_d = sel_of(mode_q, step_idx + 2'd1);
                case (state_q)
                    S_STEP1: state_d = S_STEP2;
                    S_STEP2: state_d = S_STEP3;
                    S_STEP3: state_d = S_STEP4;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 3'd0;
            sel_q   <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign address_select = sel_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_addr_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_mode_sequencer
// Function : Directed self-checking bench for addr_mode_sequencer.
// Revision : 1.0
// ============================================================================
module tb_addr_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       mem_ready = 1'b1;
    logic [3:0] address_select;
    logic       mem_req, pc_inc, dirl_load, dirh_load, indirl_load, indirh_load;
    logic       operand_valid, busy, done;

    int total = 0;
    int bad   = 0;

    // Observation word: {sel[3:0], mem_req, pc_inc, dirl, dirh, indirl, indirh, opv, busy, done}
    logic [12:0] obs;
    assign obs = {address_select, mem_req, pc_inc, dirl_load, dirh_load,
                  indirl_load, indirh_load, operand_valid, busy, done};

    addr_mode_sequencer #(.WAIT_ENABLE(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .mem_ready      (mem_ready),
        .address_select (address_select),
        .mem_req        (mem_req),
        .pc_inc         (pc_inc),
        .dirl_load      (dirl_load),
        .dirh_load      (dirh_load),
        .indirl_load    (indirl_load),
        .indirh_load    (indirh_load),
        .operand_valid  (operand_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Inputs for one cycle are {reset, start, mode[2:0], mem_ready}.
    task automatic tick(input logic [5:0] in);
        @(negedge clk);
        {reset, start, mode, mem_ready} = in;
        #1;
    endtask

    task automatic test_reset();
        tick(6'b1_0_000_1);
        tick(6'b1_0_000_1);
        for (int i = 0; i < 10; i++) begin
            tick(6'b0_0_000_1);
            total++;
            if (obs !== 13'h000) begin
                bad++;
                $display("FAIL reset_idle cyc%0d: got %h want %h", i, obs, 13'h000);
            end
        end
    endtask

    task automatic test_abs();
        logic [5:0]  in  [6] = '{6'b0_1_011_1, 6'b0_0_011_1, 6'b0_0_011_1,
                                 6'b0_0_011_1, 6'b0_0_011_1, 6'b0_0_011_1};
        logic [12:0] exp [6] = '{13'h000, 13'h1C2, 13'h1A2, 13'h506, 13'h001, 13'h000};
        for (int i = 0; i < 6; i++) begin
            tick(in[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL abs cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_izp_stall();
        logic [5:0]  in  [10] = '{6'b0_1_100_1, 6'b0_0_100_1, 6'b0_0_111_0, 6'b0_0_001_0,
                                  6'b0_0_010_0, 6'b0_0_100_1, 6'b0_0_100_1, 6'b0_0_100_1,
                                  6'b0_0_100_1, 6'b0_0_100_1};
        logic [12:0] exp [10] = '{13'h000, 13'h192, 13'h702, 13'h702, 13'h702,
                                  13'h742, 13'h922, 13'h506, 13'h001, 13'h000};
        for (int i = 0; i < 10; i++) begin
            tick(in[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL izp_stall cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  in  [10] = '{6'b0_1_101_1, 6'b0_0_101_1, 6'b0_0_101_1, 6'b0_0_101_1,
                                  6'b0_0_101_1, 6'b0_1_111_1, 6'b0_0_111_1, 6'b0_0_111_1,
                                  6'b0_0_111_1, 6'b0_0_111_1};
        logic [12:0] exp [10] = '{13'h000, 13'h192, 13'h18A, 13'hB42, 13'hD22,
                                  13'h001, 13'h1142, 13'h1322, 13'h001, 13'h000};
        for (int i = 0; i < 10; i++) begin
            tick(in[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0]  in  [7] = '{6'b0_1_011_1, 6'b0_0_011_1, 6'b1_0_011_0, 6'b0_1_001_1,
                                 6'b0_0_001_1, 6'b0_0_001_1, 6'b0_0_001_1};
        logic [12:0] exp [7] = '{13'h000, 13'h1C2, 13'h102, 13'h000,
                                 13'h186, 13'h001, 13'h000};
        for (int i = 0; i < 7; i++) begin
            tick(in[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [5:0]  in  [6] = '{6'b0_1_010_1, 6'b0_1_111_1, 6'b0_1_111_1,
                                 6'b0_0_111_1, 6'b0_0_111_1, 6'b0_0_111_1};
        logic [12:0] exp [6] = '{13'h000, 13'h1C2, 13'h306, 13'h001, 13'h000, 13'h000};
        for (int i = 0; i < 6; i++) begin
            tick(in[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL start_while_busy cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_imp_stk();
        logic [5:0]  in  [5] = '{6'b0_1_000_1, 6'b0_1_110_1, 6'b0_0_110_1,
                                 6'b0_0_110_1, 6'b0_0_110_1};
        logic [12:0] exp [5] = '{13'h000, 13'h001, 13'hF06, 13'h001, 13'h000};
        for (int i = 0; i < 5; i++) begin
            tick(in[i]);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL imp_stk cyc%0d: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_abs();
        test_izp_stall();
        test_back_to_back();
        test_reset_mid();
        test_start_while_busy();
        test_imp_stk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
